// File: rtl/dmem_if.sv
// Request/response bus between the EX/MEM stage and the data-memory LSU.
interface dmem_if #(
  parameter int unsigned ADDR_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_load;
  logic              req_store;
  logic [ADDR_W-1:0] req_addr;
  logic [2:0]        req_size;
  logic [31:0]       req_wdata;
  logic              rsp_valid;
  logic [31:0]       rsp_rdata;
  logic              rsp_fault;

  // Core side drives requests and consumes responses.
  modport master (
    output req_valid, req_load, req_store, req_addr, req_size, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_fault
  );

  // Memory side accepts requests and produces responses.
  modport slave (
    input  req_valid, req_load, req_store, req_addr, req_size, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_fault
  );
endinterface

// File: rtl/dmem_lsu.sv
// Word-organised data RAM with RV32I load/store sizing, fault detection and
// configurable read latency (RD_LAT in 1..4).
module dmem_lsu #(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned RD_LAT      = 1
) (
  input  logic   clk,
  input  logic   reset,
  dmem_if.slave  bus
);
  localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);
  localparam int unsigned CNT_W = 2;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [31:0]       hold_data;
  logic              ready_q;
  logic              valid_q;
  logic [31:0]       rdata_q;
  logic              fault_q;
  logic [31:0]       mem [DEPTH_WORDS];

  logic              accept;
  logic              fault;
  logic [IDX_W-1:0]  idx;
  logic [3:0]        be;
  logic [31:0]       wlane;
  logic [31:0]       rword;
  logic [7:0]        rbyte;
  logic [15:0]       rhalf;
  logic [31:0]       ext;

  assign bus.req_ready = ready_q;
  assign bus.rsp_valid = valid_q;
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_fault = fault_q;

  // Request decode: fault checks, byte enables, lane-replicated store data, extended load data.
  always_comb begin
    accept = bus.req_valid && ready_q;
    idx    = bus.req_addr[IDX_W+1:2];
    fault  = 1'b0;
    be     = 4'b0000;
    wlane  = bus.req_wdata;
    if (bus.req_load == bus.req_store) fault = 1'b1;
    case (bus.req_size)
      3'b000, 3'b100: ;
      3'b001, 3'b101: if (bus.req_addr[0]) fault = 1'b1;
      3'b010:         if (bus.req_addr[1:0] != 2'b00) fault = 1'b1;
      default:        fault = 1'b1;
    endcase
    if (bus.req_store && bus.req_size[2]) fault = 1'b1;
    if (|bus.req_addr[ADDR_W-1:IDX_W+2]) fault = 1'b1;

    case (bus.req_size[1:0])
      2'b00: begin
        be    = 4'b0001 << bus.req_addr[1:0];
        wlane = {4{bus.req_wdata[7:0]}};
      end
      2'b01: begin
        be    = bus.req_addr[1] ? 4'b1100 : 4'b0011;
        wlane = {2{bus.req_wdata[15:0]}};
      end
      default: begin
        be    = 4'b1111;
        wlane = bus.req_wdata;
      end
    endcase

    rword = mem[idx];
    rbyte = rword[8*bus.req_addr[1:0] +: 8];
    rhalf = bus.req_addr[1] ? rword[31:16] : rword[15:0];
    case (bus.req_size)
      3'b000:  ext = {{24{rbyte[7]}}, rbyte};
      3'b001:  ext = {{16{rhalf[15]}}, rhalf};
      3'b100:  ext = {24'h000000, rbyte};
      3'b101:  ext = {16'h0000, rhalf};
      default: ext = rword;
    endcase
  end

  // Byte-enabled store on the accept edge; RAM is intentionally not reset.
  always_ff @(posedge clk) begin
    if (accept && bus.req_store && !fault) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[idx][8*b +: 8] <= wlane[8*b +: 8];
      end
    end
  end

  // Handshake FSM with registered response outputs; load word captured at accept.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      hold_data <= '0;
      ready_q   <= 1'b1;
      valid_q   <= 1'b0;
      rdata_q   <= '0;
      fault_q   <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      rdata_q <= '0;
      fault_q <= 1'b0;
      case (state)
        IDLE, RESP: begin
          ready_q <= 1'b1;
          if (accept) begin
            if (fault) begin
              state   <= RESP;
              valid_q <= 1'b1;
              fault_q <= 1'b1;
            end else if (bus.req_store) begin
              state   <= RESP;
              valid_q <= 1'b1;
            end else if (RD_LAT == 1) begin
              state   <= RESP;
              valid_q <= 1'b1;
              rdata_q <= ext;
            end else begin
              state     <= WAIT;
              hold_data <= ext;
              cnt       <= '0;
              ready_q   <= 1'b0;
            end
          end else begin
            state <= IDLE;
          end
        end
        WAIT: begin
          if (cnt == CNT_W'(RD_LAT - 2)) begin
            state   <= RESP;
            valid_q <= 1'b1;
            rdata_q <= hold_data;
            ready_q <= 1'b1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
          state   <= IDLE;
          ready_q <= 1'b1;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_dmem_lsu.sv
// Bench for dmem_lsu: RD_LAT=1 instance driven by a vector table and random
// traffic against a byte-array model; RD_LAT=3 instance driven by hand sequences.
module tb_dmem_lsu;
  localparam int unsigned MEM_BYTES = 1024;

  typedef struct {
    logic        ld;
    logic        st;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [31:0] wdata;
    logic        exp_fault;
    logic [31:0] exp_rdata;
  } vec_t;

  logic clk = 1'b0;
  logic reset1, reset3;
  int   checks = 0;
  int   failures = 0;
  logic [7:0] mem_b [MEM_BYTES];
  vec_t vecs[$];

  dmem_if #(.ADDR_W(32)) bus1 ();
  dmem_if #(.ADDR_W(32)) bus3 ();

  dmem_lsu #(.DEPTH_WORDS(256), .ADDR_W(32), .RD_LAT(1)) u_dut1 (
    .clk(clk), .reset(reset1), .bus(bus1));
  dmem_lsu #(.DEPTH_WORDS(256), .ADDR_W(32), .RD_LAT(3)) u_dut3 (
    .clk(clk), .reset(reset3), .bus(bus3));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic ld, input logic st, input logic [31:0] addr,
                              input logic [2:0] size, input logic [31:0] wdata,
                              input logic ef, input logic [31:0] er);
    vec_t v;
    v.ld = ld; v.st = st; v.addr = addr; v.size = size; v.wdata = wdata;
    v.exp_fault = ef; v.exp_rdata = er;
    return v;
  endfunction

  // Reference: byte-addressed memory with RV32I sizing and fault rules.
  function automatic void model_op(input logic ld, input logic st, input logic [31:0] addr,
                                   input logic [2:0] size, input logic [31:0] wdata,
                                   output logic f, output logic [31:0] rd);
    int nb;
    bit uns;
    logic [31:0] val;
    nb = 0; uns = 0; f = 1'b0; rd = '0; val = '0;
    case (size)
      3'd0: nb = 1;
      3'd1: nb = 2;
      3'd2: nb = 4;
      3'd4: begin nb = 1; uns = 1; end
      3'd5: begin nb = 2; uns = 1; end
      default: f = 1'b1;
    endcase
    if (ld == st) f = 1'b1;
    if (st && size[2]) f = 1'b1;
    if (nb != 0 && (addr % nb) != 0) f = 1'b1;
    if (addr >= 32'(MEM_BYTES)) f = 1'b1;
    if (f) return;
    if (st) begin
      for (int i = 0; i < nb; i++) mem_b[int'(addr) + i] = wdata[8*i +: 8];
    end else begin
      for (int i = 0; i < nb; i++) val[8*i +: 8] = mem_b[int'(addr) + i];
      if (!uns && nb < 4 && val[8*nb-1]) begin
        for (int i = nb; i < 4; i++) val[8*i +: 8] = 8'hFF;
      end
      rd = val;
    end
  endfunction

  // Present one request to the RD_LAT=1 instance and check its N+1 response.
  task automatic apply1(input vec_t v, input string tag);
    bus1.req_valid = 1'b1;
    bus1.req_load  = v.ld;
    bus1.req_store = v.st;
    bus1.req_addr  = v.addr;
    bus1.req_size  = v.size;
    bus1.req_wdata = v.wdata;
    chk({tag, " ready"}, 32'(bus1.req_ready), 32'd1);
    @(posedge clk); #1;
    chk({tag, " valid"}, 32'(bus1.rsp_valid), 32'd1);
    chk({tag, " fault"}, 32'(bus1.rsp_fault), 32'(v.exp_fault));
    chk({tag, " rdata"}, bus1.rsp_rdata, v.exp_rdata);
  endtask

  task automatic idle1(input string tag);
    bus1.req_valid = 1'b0;
    @(posedge clk); #1;
    chk({tag, " idle valid"}, 32'(bus1.rsp_valid), 32'd0);
    chk({tag, " idle rdata"}, bus1.rsp_rdata, 32'd0);
    chk({tag, " idle fault"}, 32'(bus1.rsp_fault), 32'd0);
    chk({tag, " idle ready"}, 32'(bus1.req_ready), 32'd1);
  endtask

  task automatic set3(input logic ld, input logic st, input logic [31:0] addr,
                      input logic [2:0] size, input logic [31:0] wdata);
    bus3.req_valid = 1'b1;
    bus3.req_load  = ld;
    bus3.req_store = st;
    bus3.req_addr  = addr;
    bus3.req_size  = size;
    bus3.req_wdata = wdata;
  endtask

  task automatic step3(input string tag, input logic ev, input logic er,
                       input logic [31:0] ed, input logic ef);
    @(posedge clk); #1;
    chk({tag, " valid"}, 32'(bus3.rsp_valid), 32'(ev));
    chk({tag, " ready"}, 32'(bus3.req_ready), 32'(er));
    chk({tag, " rdata"}, bus3.rsp_rdata, ed);
    chk({tag, " fault"}, 32'(bus3.rsp_fault), 32'(ef));
  endtask

  initial begin
    vec_t v;
    logic f;
    logic [31:0] rd;
    int r;

    reset1 = 1'b1; reset3 = 1'b1;
    bus1.req_valid = 1'b0; bus1.req_load = 1'b0; bus1.req_store = 1'b0;
    bus1.req_addr = '0; bus1.req_size = '0; bus1.req_wdata = '0;
    bus3.req_valid = 1'b0; bus3.req_load = 1'b0; bus3.req_store = 1'b0;
    bus3.req_addr = '0; bus3.req_size = '0; bus3.req_wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst1 ready", 32'(bus1.req_ready), 32'd1);
    chk("rst1 valid", 32'(bus1.rsp_valid), 32'd0);
    chk("rst1 rdata", bus1.rsp_rdata, 32'd0);
    chk("rst1 fault", 32'(bus1.rsp_fault), 32'd0);
    chk("rst3 ready", 32'(bus3.req_ready), 32'd1);
    chk("rst3 valid", 32'(bus3.rsp_valid), 32'd0);
    reset1 = 1'b0; reset3 = 1'b0;

    // Preload every word of the RD_LAT=1 RAM back-to-back with a known pattern.
    for (int i = 0; i < 256; i++) begin
      v = mk(1'b0, 1'b1, 32'(i * 4), 3'b010, {16'hA5A5, 16'(i)}, 1'b0, 32'd0);
      model_op(v.ld, v.st, v.addr, v.size, v.wdata, f, rd);
      apply1(v, $sformatf("pre%0d", i));
    end
    idle1("pre");

    // Directed vectors: stores, sized loads, faults, top-of-memory boundary.
    vecs.push_back(mk(0, 1, 32'h008, 3'b010, 32'h8000_12F4, 0, 32'h0000_0000));
    vecs.push_back(mk(1, 0, 32'h008, 3'b010, 32'h0,         0, 32'h8000_12F4));
    vecs.push_back(mk(0, 1, 32'h009, 3'b000, 32'h0000_00AB, 0, 32'h0000_0000));
    vecs.push_back(mk(1, 0, 32'h009, 3'b000, 32'h0,         0, 32'hFFFF_FFAB));
    vecs.push_back(mk(1, 0, 32'h009, 3'b100, 32'h0,         0, 32'h0000_00AB));
    vecs.push_back(mk(1, 0, 32'h008, 3'b010, 32'h0,         0, 32'h8000_ABF4));
    vecs.push_back(mk(0, 1, 32'h00E, 3'b001, 32'h0000_8001, 0, 32'h0000_0000));
    vecs.push_back(mk(1, 0, 32'h00E, 3'b001, 32'h0,         0, 32'hFFFF_8001));
    vecs.push_back(mk(1, 0, 32'h00E, 3'b101, 32'h0,         0, 32'h0000_8001));
    vecs.push_back(mk(1, 0, 32'h00C, 3'b010, 32'h0,         0, 32'h8001_0003));
    vecs.push_back(mk(1, 0, 32'h002, 3'b010, 32'h0,         1, 32'h0000_0000));
    vecs.push_back(mk(0, 1, 32'h001, 3'b001, 32'h0000_1111, 1, 32'h0000_0000));
    vecs.push_back(mk(1, 0, 32'h400, 3'b000, 32'h0,         1, 32'h0000_0000));
    vecs.push_back(mk(1, 1, 32'h000, 3'b010, 32'hDEAD_BEEF, 1, 32'h0000_0000));
    vecs.push_back(mk(0, 0, 32'h000, 3'b010, 32'hDEAD_BEEF, 1, 32'h0000_0000));
    vecs.push_back(mk(1, 0, 32'h000, 3'b011, 32'h0,         1, 32'h0000_0000));
    vecs.push_back(mk(0, 1, 32'h000, 3'b100, 32'h0000_0055, 1, 32'h0000_0000));
    vecs.push_back(mk(1, 0, 32'h000, 3'b010, 32'h0,         0, 32'hA5A5_0000));
    vecs.push_back(mk(1, 0, 32'h3FF, 3'b000, 32'h0,         0, 32'hFFFF_FFA5));
    vecs.push_back(mk(1, 0, 32'h3FC, 3'b010, 32'h0,         0, 32'hA5A5_00FF));
    vecs.push_back(mk(1, 0, 32'h3FD, 3'b001, 32'h0,         1, 32'h0000_0000));
    vecs.push_back(mk(1, 0, 32'h3FE, 3'b001, 32'h0,         0, 32'hFFFF_A5A5));
    for (int i = 0; i < vecs.size(); i++) begin
      model_op(vecs[i].ld, vecs[i].st, vecs[i].addr, vecs[i].size, vecs[i].wdata, f, rd);
      apply1(vecs[i], $sformatf("vec%0d", i));
    end
    idle1("vec");

    // Random traffic against the byte-array model, with occasional idle cycles.
    for (int i = 0; i < 400; i++) begin
      r = int'($urandom_range(0, 15));
      if (r == 0)      begin v.ld = 1'b1; v.st = 1'b1; end
      else if (r == 1) begin v.ld = 1'b0; v.st = 1'b0; end
      else             begin v.ld = r[0]; v.st = !r[0]; end
      v.size  = 3'($urandom_range(0, 7));
      v.addr  = ($urandom_range(0, 9) == 0) ? 32'($urandom) : 32'($urandom_range(0, MEM_BYTES - 1));
      v.wdata = 32'($urandom);
      model_op(v.ld, v.st, v.addr, v.size, v.wdata, f, rd);
      v.exp_fault = f;
      v.exp_rdata = rd;
      apply1(v, $sformatf("rnd%0d", i));
      if ($urandom_range(0, 3) == 0) idle1($sformatf("rnd%0d", i));
    end
    idle1("rnd");

    // RD_LAT=3: store, then back-to-back load with a second request held through WAIT.
    set3(0, 1, 32'h010, 3'b010, 32'h1234_5678);
    step3("l3 st", 1, 1, 32'h0, 0);
    set3(1, 0, 32'h010, 3'b010, 32'h0);
    step3("l3 ld N+1", 0, 0, 32'h0, 0);
    set3(1, 0, 32'h012, 3'b101, 32'h0);
    step3("l3 ld N+2", 0, 0, 32'h0, 0);
    step3("l3 ld N+3", 1, 1, 32'h1234_5678, 0);
    step3("l3 b2b N+4", 0, 0, 32'h0, 0);
    bus3.req_valid = 1'b0;
    step3("l3 b2b N+5", 0, 0, 32'h0, 0);
    step3("l3 b2b N+6", 1, 1, 32'h0000_1234, 0);
    step3("l3 idle", 0, 1, 32'h0, 0);
    set3(1, 0, 32'h002, 3'b010, 32'h0);
    step3("l3 fault", 1, 1, 32'h0, 1);
    bus3.req_valid = 1'b0;
    step3("l3 fault idle", 0, 1, 32'h0, 0);

    // RD_LAT=3: reset during WAIT drops the load; a later load completes normally.
    set3(1, 0, 32'h010, 3'b010, 32'h0);
    step3("l3 rst N+1", 0, 0, 32'h0, 0);
    bus3.req_valid = 1'b0;
    reset3 = 1'b1;
    #1;
    chk("l3 rst ready", 32'(bus3.req_ready), 32'd1);
    chk("l3 rst valid", 32'(bus3.rsp_valid), 32'd0);
    chk("l3 rst rdata", bus3.rsp_rdata, 32'd0);
    chk("l3 rst fault", 32'(bus3.rsp_fault), 32'd0);
    @(posedge clk); #1;
    reset3 = 1'b0;
    for (int i = 0; i < 4; i++) step3($sformatf("l3 post rst %0d", i), 0, 1, 32'h0, 0);
    set3(1, 0, 32'h010, 3'b010, 32'h0);
    step3("l3 reld N+1", 0, 0, 32'h0, 0);
    bus3.req_valid = 1'b0;
    step3("l3 reld N+2", 0, 0, 32'h0, 0);
    step3("l3 reld N+3", 1, 1, 32'h1234_5678, 0);
    step3("l3 reld idle", 0, 1, 32'h0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/dmem_lsu.md
Name: dmem_lsu

Overview:
Parametrised successor to the single-word data memory. A word-organised data RAM for the RISC-V core with a request/response handshake and RV32I load/store sizing (LB/LH/LW/LBU/LHU, SB/SH/SW). It generates byte lanes, sign/zero-extends load data, and flags misaligned, out-of-range and illegal requests. Read latency is configurable. Sits between the EX/MEM stage and on-chip RAM.

Parameters:
DEPTH_WORDS, 256, number of 32-bit words; must be a power of 2.
ADDR_W, 32, width of the byte address.
RD_LAT, 1, cycles from load accept to rsp_valid; legal range 1..4.

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
req_valid  input  1  request present
req_ready  output  1  block can accept a request this cycle
req_load  input  1  request is a load
req_store  input  1  request is a store
req_addr  input  ADDR_W  byte address
req_size  input  3  RV32I funct3 (000 B, 001 H, 010 W, 100 BU, 101 HU)
req_wdata  input  32  store data, right-justified
rsp_valid  output  1  single-cycle response pulse
rsp_rdata  output  32  extended load data; 0 for stores and faults
rsp_fault  output  1  request rejected; memory unchanged

Behaviour:
- Reset (async): state to IDLE, latency counter to 0, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_fault=0. RAM contents are not cleared.
- Accept: a request is accepted on a rising edge where req_valid && req_ready. Call the cycle the request is presented cycle N.
- States:
  - IDLE: req_ready=1.
  - WAIT: load in flight, counter running; req_ready=0.
  - RESP: rsp_valid=1; req_ready=1.
- Transitions:
  - From IDLE or RESP, an accept goes to RESP when the request is a store, a fault, or a load with RD_LAT=1. It goes to WAIT for a load with RD_LAT>1. With no accept, the block returns to IDLE.
  - WAIT goes to RESP after RD_LAT-1 cycles.
- Timing:
  - Store and fault responses: rsp_valid in cycle N+1.
  - Load responses: rsp_valid in cycle N+RD_LAT.
  - A new request may be accepted in the RESP cycle (back-to-back). With RD_LAT=1, throughput is one request per cycle.
- Fault conditions, checked at accept:
  - req_load and req_store both 1, or both 0.
  - Illegal size: 011, 110 or 111, or a store with size 1xx.
  - Misaligned: H/HU with addr[0]=1, or W with addr[1:0]!=0.
  - Out of range: word index addr[ADDR_W-1:2] >= DEPTH_WORDS.
  - On a fault: no write occurs, rsp_fault=1, rsp_rdata=0.
- Store write:
  - Written on the accept edge, using byte enables.
  - SB: byte lane addr[1:0] gets wdata[7:0].
  - SH: lanes addr[1]*2 +{0,1} get wdata[15:0].
  - SW: all four lanes.
  - Untouched lanes keep their value.
- Load read:
  - The word is captured on the accept edge, so a load issued the cycle after a store sees the stored data.
  - Byte select is addr[1:0]; halfword select is addr[1].
  - B/H are sign-extended to 32 bits; BU/HU are zero-extended.
- Outputs: rsp_rdata and rsp_fault are valid only while rsp_valid=1 and are 0 otherwise.
- Reset mid-WAIT: the in-flight load is discarded with no response. The block returns to IDLE with req_ready=1.
- Inputs sampled while req_ready=0 are ignored.

Test Plan:
1. Reset, then SW 0x8000_12F4 @0x008 (N), then LW @0x008 -> store rsp_valid at N+1 with fault=0 and rdata=0; load returns 0x8000_12F4.
2. After test 1, SB 0xAB @0x009, then LB @0x009, LBU @0x009, LW @0x008 -> 0xFFFF_FFAB, 0x0000_00AB, 0x8000_ABF4.
3. SH 0x8001 @0x00E, then LH @0x00E and LHU @0x00E -> 0xFFFF_8001, 0x0000_8001; the word @0x00C keeps its lower half.
4. Faults: LW @0x002; SH @0x001; LB @0x400 (DEPTH_WORDS=256); load and store both set; size 011 -> each gives rsp_fault=1, rdata=0 at N+1. A following LW @0x000 shows memory unchanged.
5. RD_LAT=3, LW @0x010 at cycle N -> req_ready=0 in N+1..N+2, rsp_valid in N+3. A back-to-back request presented in N+3 is accepted, and its rsp_valid arrives at N+6.
6. RD_LAT=3, assert reset in cycle N+1 of a load -> no rsp_valid, req_ready=1, outputs 0. A subsequent LW completes normally.
